// File: rtl/rom_burst_reader.sv
// Burst reader for a DTI ROM read port: issues `count` consecutive addresses
// and streams the returned words out as a Queue (data + eot), credit-limited to DEPTH.
module rom_burst_reader #(
    parameter int W_DATA = 16,
    parameter int W_ADDR = 16,
    parameter int W_CNT  = 16,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_if_valid,
    input  logic [W_CNT+W_ADDR-1:0] cmd_if_data,
    output logic                    cmd_if_ready,
    output logic                    rd_addr_if_valid,
    output logic [W_ADDR-1:0]       rd_addr_if_data,
    input  logic                    rd_addr_if_ready,
    input  logic                    rd_data_if_valid,
    input  logic [W_DATA-1:0]       rd_data_if_data,
    output logic                    rd_data_if_ready,
    output logic                    dout_if_valid,
    output logic [W_DATA:0]         dout_if_data,
    input  logic                    dout_if_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state_q, state_d;
    logic               cmd_rdy_q, cmd_rdy_d;
    logic [W_ADDR-1:0]  addr_q, addr_d;
    logic [W_CNT-1:0]   cnt_q, cnt_d;
    logic [W_CNT-1:0]   iss_cnt_q, iss_cnt_d;
    logic [W_CNT-1:0]   out_cnt_q, out_cnt_d;
    logic [CW-1:0]      credit_q, credit_d;
    logic [PW:0]        wr_ptr_q, wr_ptr_d;
    logic [PW:0]        rd_ptr_q, rd_ptr_d;
    logic [W_DATA-1:0]  mem_q [DEPTH];

    logic cmd_hs, addr_hs, push, pop, empty, full, eot;

    assign cmd_hs  = cmd_if_valid & cmd_rdy_q;
    assign addr_hs = rd_addr_if_valid & rd_addr_if_ready;
    assign push    = rd_data_if_valid & rd_data_if_ready;
    assign pop     = dout_if_valid & dout_if_ready;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign eot     = (out_cnt_q == cnt_q - W_CNT'(1));

    // Ready is registered so it is low throughout reset even though the FSM sits in IDLE.
    assign cmd_if_ready     = cmd_rdy_q;
    assign rd_addr_if_valid = (state_q == ISSUE) && (credit_q != '0);
    assign rd_addr_if_data  = addr_q;
    assign rd_data_if_ready = !full;
    assign dout_if_valid    = !empty;
    assign dout_if_data     = {eot, mem_q[rd_ptr_q[PW-1:0]]};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        iss_cnt_d = iss_cnt_q;
        out_cnt_d = out_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    addr_d    = cmd_if_data[W_ADDR-1:0];
                    cnt_d     = cmd_if_data[W_CNT+W_ADDR-1:W_ADDR];
                    iss_cnt_d = '0;
                    out_cnt_d = '0;
                    if (cmd_if_data[W_CNT+W_ADDR-1:W_ADDR] != '0)
                        state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (addr_hs) begin
                    addr_d    = addr_q + W_ADDR'(1);
                    iss_cnt_d = iss_cnt_q + W_CNT'(1);
                    if (iss_cnt_q + W_CNT'(1) == cnt_q)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && eot)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (pop)
            out_cnt_d = out_cnt_q + W_CNT'(1);
        cmd_rdy_d = (state_d == IDLE);
        // A slot is reserved at address issue and released only when the word leaves,
        // so the buffer always has room for everything in flight.
        credit_d  = credit_q - CW'(addr_hs) + CW'(pop);
        wr_ptr_d  = wr_ptr_q + {{PW{1'b0}}, push};
        rd_ptr_d  = rd_ptr_q + {{PW{1'b0}}, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_rdy_q <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            iss_cnt_q <= '0;
            out_cnt_q <= '0;
            credit_q  <= CW'(DEPTH);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_rdy_q <= cmd_rdy_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            iss_cnt_q <= iss_cnt_d;
            out_cnt_q <= out_cnt_d;
            credit_q  <= credit_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[PW-1:0]] <= rd_data_if_data;
    end
endmodule
